// File: rtl/io_write_arbiter.sv
// io_write_arbiter: round-robin arbiter that funnels three requesters'
// single-word writes into one IO output port. One grant per two cycles:
// IDLE arbitrates and latches the winner, WRITE presents the strobe.
// Writes to addresses outside the port window are acked with err and
// never strobed. Saturating counters track committed and rejected writes.

// Per-requester address decode: the port window is addr[7:2] in 0x20..0x22.
module io_addr_check (
  input  logic [5:0] word_sel,
  output logic       ok
);
  // Word-select decode of the three port registers
  always_comb ok = (word_sel == 6'b100000) || (word_sel == 6'b100001) ||
                   (word_sel == 6'b100010);
endmodule

module io_write_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic             io_clk,
  input  logic             clrn,
  input  logic [2:0]       req,
  input  logic [31:0]      addr0,
  input  logic [31:0]      addr1,
  input  logic [31:0]      addr2,
  input  logic [31:0]      data0,
  input  logic [31:0]      data1,
  input  logic [31:0]      data2,
  output logic [2:0]       ack,
  output logic [2:0]       err,
  output logic [31:0]      io_addr,
  output logic [31:0]      io_datain,
  output logic             write_io_enable,
  output logic             busy,
  output logic [CNT_W-1:0] wr_count,
  output logic [CNT_W-1:0] err_count
);
  localparam int NUM_REQ = 3;

  typedef enum logic {IDLE = 1'b0, WRITE = 1'b1} state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_req_t;

  wr_req_t [NUM_REQ-1:0] rq;
  logic    [NUM_REQ-1:0] addr_ok;

  state_t      state, state_nxt;
  logic [1:0]  ptr;
  logic [1:0]  win;
  logic        win_found;
  logic        grant;
  logic [2:0]  win_oh;
  logic [2:0]  ack_nxt, err_nxt;
  logic        wen_nxt;

  assign rq[0] = {addr0, data0};
  assign rq[1] = {addr1, data1};
  assign rq[2] = {addr2, data2};

  // Only addr[7:2] matters for validity; the rest of the address is ignored
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_lane
      io_addr_check u_chk (
        .word_sel (rq[gi].addr[7:2]),
        .ok       (addr_ok[gi])
      );
    end
  endgenerate

  // (a + b) mod 3 for a, b in 0..2
  function automatic logic [1:0] mod3_add(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

  // Round-robin pick: first requester set scanning ptr, ptr+1, ptr+2
  always_comb begin
    win       = 2'd0;
    win_found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!win_found && req[mod3_add(ptr, 2'(k))]) begin
        win_found = 1'b1;
        win       = mod3_add(ptr, 2'(k));
      end
    end
  end

  // State register; reset forces IDLE without waiting for a clock
  always_ff @(posedge io_clk or negedge clrn) begin
    if (!clrn) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state: a request in IDLE always wins a WRITE cycle, WRITE lasts one cycle
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req) state_nxt = WRITE;
      WRITE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode: next-cycle strobes, registered below so they line up with WRITE
  always_comb begin
    busy    = (state == WRITE);
    grant   = (state == IDLE) && win_found;
    win_oh  = 3'b001 << win;
    ack_nxt = 3'b000;
    err_nxt = 3'b000;
    wen_nxt = 1'b0;
    if (grant) begin
      ack_nxt = win_oh;
      if (addr_ok[win]) wen_nxt = 1'b1;
      else              err_nxt = win_oh;
    end
  end

  // Registered strobes, latched port address/data, pointer and counters.
  // Counts update on the grant edge so they are current during WRITE.
  always_ff @(posedge io_clk or negedge clrn) begin
    if (!clrn) begin
      ack             <= '0;
      err             <= '0;
      write_io_enable <= 1'b0;
      io_addr         <= '0;
      io_datain       <= '0;
      ptr             <= 2'd0;
      wr_count        <= '0;
      err_count       <= '0;
    end else begin
      ack             <= ack_nxt;
      err             <= err_nxt;
      write_io_enable <= wen_nxt;
      if (grant) begin
        io_addr   <= rq[win].addr;
        io_datain <= rq[win].data;
        ptr       <= mod3_add(win, 2'd1);
      end
      if (wen_nxt && (wr_count != '1))  wr_count  <= wr_count + 1'b1;
      if ((|err_nxt) && (err_count != '1)) err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: doc/io_write_arbiter.md
IO_WRITE_ARBITER -- requirements
Module: io_write_arbiter

Interface
REQ-001 Parameter: CNT_W, default 16, width of the committed-write and error counters.
REQ-002 io_clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 clrn  input  1  reset, asynchronous and active-low.
REQ-004 req  input  3  per-requester write request; bit i belongs to requester i.
REQ-005 addr0, addr1, addr2  input  32 each  write address of requester 0/1/2.
REQ-006 data0, data1, data2  input  32 each  write data of requester 0/1/2.
REQ-007 ack  output  3  registered one-cycle completion pulse, per requester.
REQ-008 err  output  3  registered; high with ack[i] when requester i's address was invalid.
REQ-009 io_addr  output  32  registered address to the IO output port block.
REQ-010 io_datain  output  32  registered data to the IO output port block.
REQ-011 write_io_enable  output  1  registered write strobe to the IO output port block.
REQ-012 busy  output  1  high while the FSM is in WRITE.
REQ-013 wr_count  output  CNT_W  committed valid writes, saturating.
REQ-014 err_count  output  CNT_W  rejected invalid writes, saturating.

Function
REQ-015 The FSM SHALL have exactly two states, IDLE and WRITE.
REQ-016 In IDLE with req==0, the FSM SHALL stay in IDLE and all strobes SHALL be 0.
REQ-017 In IDLE with req!=0, the winner SHALL be chosen round-robin: first set bit scanning ptr, ptr+1, ptr+2 (mod 3).
REQ-018 On that edge: latch winner's addr/data into io_addr/io_datain; set ack[winner]=1; enter WRITE; ptr=(winner+1) mod 3.
REQ-019 Valid address: addr[7:2] is 6'b100000, 6'b100001 or 6'b100010; addr[31:8] and addr[1:0] are ignored.
REQ-020 Valid winner: write_io_enable=1 and err[winner]=0 for exactly the WRITE cycle.
REQ-021 Invalid winner: write_io_enable=0, err[winner]=1, ack[winner]=1 for the WRITE cycle.
REQ-022 Invalid winner: ptr advances exactly as for a valid winner.
REQ-023 In WRITE, no arbitration SHALL occur; next edge SHALL return to IDLE and clear ack, err, write_io_enable.
REQ-024 Throughput: at most one grant per two cycles; latency from req sampled in IDLE to ack visible is one cycle.
REQ-025 Handshake: requester holds req/addr/data stable until it samples ack=1.
REQ-026 At that edge the requester either drops req or presents a new transaction with req held high.
REQ-027 Arbitration in the following IDLE cycle SHALL treat a held req as a new request.
REQ-028 io_addr/io_datain SHALL hold their last values outside WRITE.
REQ-029 wr_count SHALL increment on each valid WRITE cycle and saturate at all-ones.
REQ-030 err_count SHALL increment on each invalid WRITE cycle and saturate at all-ones.
REQ-031 Requests that change or drop while not granted SHALL have no effect; no request is queued internally.

Reset
REQ-032 clrn=0 SHALL immediately, without a clock edge, set state=IDLE and ptr=0.
REQ-033 clrn=0 SHALL clear ack, err, write_io_enable, busy, io_addr, io_datain, wr_count and err_count to 0.
REQ-034 Reset asserted during WRITE SHALL drop write_io_enable at once; the write SHALL NOT be counted or retried.
REQ-035 After clrn deasserts, the first arbitration SHALL occur at the first rising edge with clrn=1 and state IDLE.

Verification
REQ-036 req=3'b001, addr0=0x80, data0=0x1234 -> next cycle: write_io_enable=1, io_addr=0x80, io_datain=0x1234, ack=001, err=000; wr_count=1.
REQ-037 req=3'b111 held, distinct data -> grants 0,1,2,0 on alternate cycles; write_io_enable pulses 1,0,1,0...
REQ-038 req=3'b010, addr1=0x8C (addr[7:2]=100011) -> ack=010, err=010, write_io_enable=0; err_count=1, wr_count unchanged.
REQ-039 clrn pulsed low during WRITE -> write_io_enable/ack drop asynchronously; ptr=0; counts=0; next req=3'b110 grants requester 1.
REQ-040 Preload wr_count to all-ones via 2^CNT_W valid writes (CNT_W overridden to 4 for this test) -> count stays 4'hF.
REQ-041 Requester 2 holds req with new addr/data after ack, others idle -> second write issues two cycles after the first.
